counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 4, counter/data width in bits; legal range 2..32.
REQ-002 Parameter STEP, default 3, increment applied in MODO=00; legal range 1..2^WIDTH-1.
REQ-003 Parameter WRAP, default 1, overflow policy: 1 = modulo-2^WIDTH wrap, 0 = saturate at 0 / MAX.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 ENABLE  input  1  global enable; 0 freezes the counter.
REQ-007 CI  input  1  cascade carry-in; gates counting modes for chained instances.
REQ-008 MODO  input  2  operation select: 00 up by STEP, 01 down by 1, 10 up by 1, 11 load D.
REQ-009 D  input  WIDTH  parallel load value.
REQ-010 Q  output  WIDTH  registered count.
REQ-011 RCO  output  1  registered ripple-carry/borrow pulse.
REQ-012 LOAD  output  1  registered pulse: a load was performed this cycle.

Function
REQ-013 Q, RCO and LOAD SHALL all be registers; every effect is visible one CLK edge after the inputs that cause it (latency 1).
REQ-014 MAX SHALL equal 2^WIDTH-1; sums and differences SHALL be evaluated in WIDTH+1 bits to detect carry/borrow.
REQ-015 Priority per edge SHALL be: RESET, then ENABLE=0, then MODO=11, then CI=0, then counting modes.
REQ-016 ENABLE=0: Q SHALL hold; RCO and LOAD SHALL be 0.
REQ-017 MODO=11 with ENABLE=1: Q SHALL take D, LOAD SHALL be 1, RCO SHALL be 0; CI SHALL NOT gate loads.
REQ-018 Counting mode with CI=0: Q SHALL hold; RCO and LOAD SHALL be 0.
REQ-019 MODO=00, CI=1: if Q+STEP <= MAX then Q <= Q+STEP, RCO=0; else RCO=1 and Q <= (Q+STEP) mod 2^WIDTH (WRAP=1) or MAX (WRAP=0).
REQ-020 MODO=10, CI=1: if Q < MAX then Q <= Q+1, RCO=0; else RCO=1 and Q <= 0 (WRAP=1) or MAX (WRAP=0).
REQ-021 MODO=01, CI=1: if Q > 0 then Q <= Q-1, RCO=0; else RCO=1 and Q <= MAX (WRAP=1) or 0 (WRAP=0).
REQ-022 In saturate mode RCO SHALL reassert on every counting edge that attempts to pass the bound, including repeated attempts while held at the bound.
REQ-023 LOAD SHALL be 0 in every non-load cycle; RCO and LOAD SHALL never both be 1.
REQ-024 Mode changes SHALL take effect on the next edge with no pipeline flush or dead cycle.
REQ-025 Chaining: RCO of stage n feeds CI of stage n+1 with a common ENABLE; the chain advances one stage per carry with one cycle of lag per stage.

Reset
REQ-026 RESET=1 at a rising edge SHALL set Q=0, RCO=0, LOAD=0, regardless of ENABLE, CI, MODO and D.
REQ-027 RESET asserted mid-operation (including during a load) SHALL abort that operation; counting resumes from 0 on the first edge after RESET deasserts.
REQ-028 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply reset before checking.

Verification (WIDTH=4, STEP=3 unless stated)
REQ-029 Reset: RESET=1 for 2 edges with ENABLE=1, MODO=10, CI=1 -> Q=0, RCO=0, LOAD=0 on both edges.
REQ-030 Step wrap, WRAP=1: from Q=0, MODO=00, CI=1 -> Q=3,6,9,C,F,2; RCO=1 only on the edge producing 2.
REQ-031 Load/down: MODO=11, D=A -> Q=A, LOAD=1 for 1 cycle; then MODO=01 -> Q=9, LOAD=0, RCO=0.
REQ-032 Saturate down, WRAP=0: Q=1, MODO=01 for 3 edges -> Q=0,0,0; RCO=0,1,1.
REQ-033 Gating: ENABLE=0 -> Q holds, RCO=LOAD=0; ENABLE=1, CI=0, MODO=10 -> Q holds; CI=0, MODO=11, D=5 -> Q=5, LOAD=1.
REQ-034 Reset during load: MODO=11, D=F, RESET=1 -> Q=0, LOAD=0; next edge RESET=0, MODO=10, CI=1 -> Q=1.

Source files
------------

// File: rtl/counter_param.sv
// Parameterised step/up/down counter with parallel load, cascade carry and wrap/saturate policy.
// Latency 1 cycle on Q/RCO/LOAD; no backpressure, ENABLE=0 or CI=0 simply freezes the count.
module counter_param #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             CI,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD
);

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH:0] MAX    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    // One extra bit on each path exposes carry/borrow directly.
    logic [WIDTH:0] sum_step;
    logic [WIDTH:0] sum_one;
    logic [WIDTH:0] diff_one;

    assign sum_step = {1'b0, Q} + STEP_X;
    assign sum_one  = {1'b0, Q} + 1'b1;
    assign diff_one = {1'b0, Q} - 1'b1;

    logic [WIDTH-1:0] q_nxt;
    logic             rco_nxt;
    logic             load_nxt;

    always_comb begin
        q_nxt    = Q;
        rco_nxt  = 1'b0;
        load_nxt = 1'b0;
        if (ENABLE) begin
            if (MODO == MODE_LOAD) begin
                q_nxt    = D;
                load_nxt = 1'b1;
            end else if (CI) begin
                case (MODO)
                    MODE_STEP: begin
                        q_nxt = sum_step[WIDTH-1:0];
                        if (sum_step > MAX) begin
                            rco_nxt = 1'b1;
                            if (!WRAP) q_nxt = MAX[WIDTH-1:0];
                        end
                    end
                    MODE_UP: begin
                        q_nxt = sum_one[WIDTH-1:0];
                        if (sum_one[WIDTH]) begin
                            rco_nxt = 1'b1;
                            if (!WRAP) q_nxt = MAX[WIDTH-1:0];
                        end
                    end
                    MODE_DOWN: begin
                        q_nxt = diff_one[WIDTH-1:0];
                        if (diff_one[WIDTH]) begin
                            rco_nxt = 1'b1;
                            if (!WRAP) q_nxt = '0;
                        end
                    end
                    default: q_nxt = Q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q    <= '0;
            RCO  <= 1'b0;
            LOAD <= 1'b0;
        end else begin
            Q    <= q_nxt;
            RCO  <= rco_nxt;
            LOAD <= load_nxt;
        end
    end

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: wrapping and saturating instances share stimulus; a scoreboard
// of directed expectations plus a behavioural model is drained after every edge.
module tb_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ci;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q_w, q_s;
    logic       rco_w, rco_s, load_w, load_s;

    counter_param #(.WIDTH(4), .STEP(3), .WRAP(1'b1)) u_wrap (
        .CLK(clk), .RESET(rst), .ENABLE(en), .CI(ci), .MODO(modo), .D(d),
        .Q(q_w), .RCO(rco_w), .LOAD(load_w)
    );

    counter_param #(.WIDTH(4), .STEP(3), .WRAP(1'b0)) u_sat (
        .CLK(clk), .RESET(rst), .ENABLE(en), .CI(ci), .MODO(modo), .D(d),
        .Q(q_s), .RCO(rco_s), .LOAD(load_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;   // 0 = wrapping instance, 1 = saturating instance
        logic [3:0] q;
        logic       rco;
        logic       load;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic [3:0] mw = '0;
    logic [3:0] ms = '0;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got q=%h rco=%b load=%b, expected q=%h rco=%b load=%b",
                     tag, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
        end
    endtask

    task automatic expect_v(input string tag, input logic sel, input logic [3:0] q,
                            input logic rco, input logic load);
        exp_t e;
        e.sel = sel; e.q = q; e.rco = rco; e.load = load;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Reference behaviour, written from the operation table in plain integer arithmetic.
    function automatic logic [5:0] mdl(input logic [3:0] q, input logic r, input logic e,
                                       input logic c, input logic [1:0] m,
                                       input logic [3:0] dv, input bit wrap);
        int s;
        if (r) return 6'b0;
        if (!e) return {q, 2'b00};
        if (m == 2'b11) return {dv, 2'b01};
        if (!c) return {q, 2'b00};
        case (m)
            2'b00: begin
                s = int'(q) + 3;
                if (s > 15) return {(wrap ? 4'(s - 16) : 4'hF), 2'b10};
                return {4'(s), 2'b00};
            end
            2'b10: begin
                if (q == 4'hF) return {(wrap ? 4'h0 : 4'hF), 2'b10};
                return {4'(int'(q) + 1), 2'b00};
            end
            default: begin
                if (q == 4'h0) return {(wrap ? 4'hF : 4'h0), 2'b10};
                return {4'(int'(q) - 1), 2'b00};
            end
        endcase
    endfunction

    // Drive one edge's inputs, queue model results, then drain the scoreboard after the edge.
    task automatic cyc(input logic r, input logic e, input logic c,
                       input logic [1:0] m, input logic [3:0] dv);
        logic [5:0] nw, ns;
        exp_t  x;
        string t;
        rst = r; en = e; ci = c; modo = m; d = dv;
        nw = mdl(mw, r, e, c, m, dv, 1'b1);
        ns = mdl(ms, r, e, c, m, dv, 1'b0);
        expect_v("model_wrap", 1'b0, nw[5:2], nw[1], nw[0]);
        expect_v("model_sat", 1'b1, ns[5:2], ns[1], ns[0]);
        mw = nw[5:2];
        ms = ns[5:2];
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            if (x.sel) check(t, {q_s, rco_s, load_s}, {x.q, x.rco, x.load});
            else       check(t, {q_w, rco_w, load_w}, {x.q, x.rco, x.load});
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ci = 1'b1; modo = 2'b10; d = 4'h0;

        // Reset held for two edges while counting inputs are active.
        for (int i = 0; i < 2; i++) begin
            expect_v("reset_wrap", 1'b0, 4'h0, 1'b0, 1'b0);
            expect_v("reset_sat", 1'b1, 4'h0, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b1, 2'b10, 4'h0);
        end

        // Step by 3: wrap instance rolls over to 2, saturating instance sticks at F.
        begin
            logic [3:0] seq_w[6] = '{4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h2};
            logic [3:0] seq_s[6] = '{4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'hF};
            for (int i = 0; i < 6; i++) begin
                expect_v("step_wrap", 1'b0, seq_w[i], (i == 5), 1'b0);
                expect_v("step_sat", 1'b1, seq_s[i], (i == 5), 1'b0);
                cyc(1'b0, 1'b1, 1'b1, 2'b00, 4'h0);
            end
        end

        // Load A then count down once.
        expect_v("load_a", 1'b0, 4'hA, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'hA);
        expect_v("down_after_load", 1'b0, 4'h9, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'b01, 4'h0);

        // Load 1 then three down edges: saturate holds 0 with repeated RCO; wrap goes 0,F,E.
        cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'h1);
        begin
            logic [3:0] dw[3] = '{4'h0, 4'hF, 4'hE};
            for (int i = 0; i < 3; i++) begin
                expect_v("sat_down", 1'b1, 4'h0, (i != 0), 1'b0);
                expect_v("wrap_down", 1'b0, dw[i], (i == 1), 1'b0);
                cyc(1'b0, 1'b1, 1'b1, 2'b01, 4'h0);
            end
        end

        // Gating: ENABLE low, then CI low in count mode, then CI low with a load.
        expect_v("enable_low", 1'b1, 4'h0, 1'b0, 1'b0);
        expect_v("enable_low_w", 1'b0, 4'hE, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'b11, 4'h7);
        expect_v("ci_low_hold", 1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'b10, 4'h0);
        expect_v("ci_low_load", 1'b1, 4'h5, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 4'h5);

        // Up-count at MAX in saturate mode keeps pulsing RCO.
        cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'hF);
        expect_v("sat_up_max", 1'b1, 4'hF, 1'b1, 1'b0);
        expect_v("wrap_up_max", 1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'b10, 4'h0);

        // Reset wins over a load, counting restarts from 0.
        expect_v("reset_in_load", 1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'hF);
        expect_v("after_reset_up", 1'b0, 4'h1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'b10, 4'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
